poly_voice_alloc: RTL and testbench
===================================

POLY_VOICE_ALLOC -- requirements
Module: poly_voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of simultaneous tone voices (1..8).
REQ-002 SHALL have parameter DIV_WIDTH, default 22, width of the half-period divider per voice.
REQ-003 SHALL have parameter AMPLITUDE, default 16'h1000, per-voice signed square-wave magnitude.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1; 0 mutes both audio outputs.
REQ-007 SHALL have port key_valid, input, 1, one-cycle key event strobe.
REQ-008 SHALL have port key_code, input, 9, scan code of the event.
REQ-009 SHALL have port key_pressed, input, 1; 1 = make, 0 = break; sampled with key_valid.
REQ-010 SHALL have port note_div, input, DIV_WIDTH, half-period divider for key_code; sampled with key_valid.
REQ-011 SHALL have port voice_active, output, NUM_VOICES, per-voice busy flags.
REQ-012 SHALL have port drop, output, 1, one-cycle pulse when a make event is discarded or a voice is stolen.
REQ-013 SHALL have port audio_left, output, 16, signed mix of even-index voices.
REQ-014 SHALL have port audio_right, output, 16, signed mix of odd-index voices; with NUM_VOICES=1, it duplicates audio_left.

Function
REQ-015 Each voice SHALL hold: busy, key (9b), div (DIV_WIDTH), counter (DIV_WIDTH), phase (1b), age (3b).
REQ-016 A make event whose key_code already matches a busy voice SHALL be ignored, with no state change and no drop pulse.
REQ-017 A make event with a free voice SHALL allocate the lowest-index free voice.
  - Loads key and div, clears counter, phase and age.
  - Sets busy, visible on voice_active in the next cycle.
REQ-018 On every allocation, all other busy voices SHALL increment age, saturating at 7.
REQ-019 A break event SHALL clear busy on the voice holding key_code in the next cycle. A break for an unheld key SHALL be ignored.
REQ-020 Each busy voice with div != 0 SHALL count counter 0..div-1, toggle phase and reset counter to 0 when counter == div-1.
  - Its output is +AMPLITUDE when phase=1 and -AMPLITUDE when phase=0.
REQ-021 A free voice, or a busy voice with div == 0, SHALL contribute 0 to the mix.
REQ-022 Each mix SHALL be summed at 19-bit signed width and saturated to 16'h7FFF / 16'h8000.
REQ-023 audio_left/right SHALL be registered: the mix of the voice state of cycle t appears at cycle t+1.
REQ-024 With enable=0, audio_left/right SHALL be 0 from the next cycle. Voice allocation, release and counting SHALL continue unaffected.
REQ-025 Only one event per cycle SHALL exist. key_valid asserted on consecutive cycles SHALL process each event in order, with each decision seeing the previous event's update.

Reset
REQ-026 rst=1 at a clock edge SHALL clear all voice fields; voice_active=0, drop=0, audio_left=audio_right=0 from the next cycle.
REQ-027 An event coincident with rst=1 SHALL be discarded. rst asserted mid-note SHALL silence all voices in one cycle.

Configuration
REQ-028 Macro POLY_VOICE_STEAL_EN SHALL select full-allocation behaviour.
  - Defined: a make event with all voices busy steals the voice with the highest age (lowest index on ties), reloads it as per REQ-017 and pulses drop.
  - Undefined: a make event with all voices busy is discarded, state is unchanged and drop pulses.

Verification
REQ-029 Reset, then make key 9'h01C with div=4, NUM_VOICES=4 -> voice_active=4'b0001 after 1 cycle; audio_left toggles +16'h1000/-16'h1000 every 4 cycles; audio_right=0.
REQ-030 Make keys 1C, 1B, 23, 2B, then make 34 -> with STEAL_EN: voice0 reloaded with 34, drop pulses 1 cycle, voice_active=4'b1111; without STEAL_EN: voice0 keeps 1C, drop pulses.
REQ-031 Make 1C twice, then break 1C -> second make ignored with no drop; voice_active returns to 0 one cycle after the break.
REQ-032 Break of unheld key 9'h015 -> no state change; make 1C with div=0 -> voice_active=1, audio=0.
REQ-033 NUM_VOICES=8, AMPLITUDE=16'h4000, four even voices in phase=1 -> audio_left saturates at 16'h7FFF; enable=0 -> audio_left=0 next cycle while voice_active stays 8'h55.
REQ-034 Assert rst while 3 voices sound -> next cycle voice_active=0 and audio=0; an event in the rst cycle is ignored.

Source files
------------

// File: rtl/poly_voice_alloc.sv
// rtl/poly_voice_alloc.sv - polyphonic square-wave voice allocator and stereo mixer
//
// Purpose: turns make/break key events into up to NUM_VOICES square-wave tones.
//    Even-index voices are mixed to audio_left and odd-index voices to audio_right.
//    Each mix is saturated to 16 bits and registered.
// Ports:
//    clk, rst          single clock, synchronous active-high reset
//    enable            0 mutes both audio outputs; the voices keep running
//    key_valid         one-cycle event strobe, qualifies key_code/key_pressed/note_div
//    key_code          9-bit scan code of the event
//    key_pressed       1 = make, 0 = break
//    note_div          half-period divider loaded into the allocated voice
//    voice_active      per-voice busy flags
//    drop              one-cycle pulse when a make is discarded or a voice is stolen
//    audio_left/right  signed 16-bit mixes (right duplicates left when NUM_VOICES == 1)
// Build option: POLY_VOICE_STEAL_EN - when defined, a make event with every voice busy
//    steals the oldest voice; otherwise that make event is discarded.
module poly_voice_alloc #(
   parameter int                 NUM_VOICES = 4,
   parameter int                 DIV_WIDTH  = 22,
   parameter logic signed [15:0] AMPLITUDE  = 16'sh1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     key_valid,
   input  logic [8:0]               key_code,
   input  logic                     key_pressed,
   input  logic [DIV_WIDTH-1:0]     note_div,
   output logic [NUM_VOICES-1:0]    voice_active,
   output logic                     drop,
   output logic signed [15:0]       audio_left,
   output logic signed [15:0]       audio_right
);

`ifdef POLY_VOICE_STEAL_EN
   localparam bit STEAL_EN = 1'b1;
`else
   localparam bit STEAL_EN = 1'b0;
`endif

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic signed [18:0] MIX_MAX = 19'sd32767;
   localparam logic signed [18:0] MIX_MIN = -19'sd32768;

   // per-voice state
   logic [NUM_VOICES-1:0] busy;
   logic [NUM_VOICES-1:0] phase;
   logic [8:0]            key_q [NUM_VOICES];
   logic [DIV_WIDTH-1:0]  div_q [NUM_VOICES];
   logic [DIV_WIDTH-1:0]  cnt_q [NUM_VOICES];
   logic [2:0]            age_q [NUM_VOICES];

   // event decode
   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] old_idx;
   logic [2:0]       old_age;
   logic             is_make;
   logic             alloc_en;
   logic [IDX_W-1:0] alloc_idx;
   logic             release_en;
   logic             drop_d;

   // mixing
   logic signed [18:0] amp_ext;
   logic signed [18:0] contrib;
   logic signed [18:0] mix_l;
   logic signed [18:0] mix_r;

   assign voice_active = busy;

   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      old_idx    = '0;
      old_age    = age_q[0];
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (busy[i] && key_q[i] == key_code) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
      // walking downwards leaves the lowest free index as the winner
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      // strict compare keeps the lowest index on equal ages
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (age_q[i] > old_age) begin
            old_age = age_q[i];
            old_idx = IDX_W'(i);
         end
      end
      is_make    = key_valid && key_pressed && !hit;
      alloc_en   = is_make && (free_found || STEAL_EN);
      alloc_idx  = free_found ? free_idx : old_idx;
      drop_d     = is_make && !free_found;
      release_en = key_valid && !key_pressed && hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy  <= '0;
         phase <= '0;
         drop  <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            key_q[i] <= '0;
            div_q[i] <= '0;
            cnt_q[i] <= '0;
            age_q[i] <= '0;
         end
      end else begin
         drop <= drop_d;
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (alloc_en && alloc_idx == IDX_W'(i)) begin
               busy[i]  <= 1'b1;
               phase[i] <= 1'b0;
               key_q[i] <= key_code;
               div_q[i] <= note_div;
               cnt_q[i] <= '0;
               age_q[i] <= '0;
            end else begin
               if (release_en && hit_idx == IDX_W'(i))
                  busy[i] <= 1'b0;
               if (alloc_en && busy[i] && age_q[i] != 3'd7)
                  age_q[i] <= age_q[i] + 3'd1;
               if (busy[i] && div_q[i] != '0) begin
                  if (cnt_q[i] == div_q[i] - DIV_WIDTH'(1)) begin
                     cnt_q[i] <= '0;
                     phase[i] <= ~phase[i];
                  end else begin
                     cnt_q[i] <= cnt_q[i] + DIV_WIDTH'(1);
                  end
               end
            end
         end
      end
   end

   always_comb begin
      amp_ext = 19'(AMPLITUDE);
      mix_l   = '0;
      mix_r   = '0;
      contrib = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         contrib = '0;
         if (busy[i] && div_q[i] != '0)
            contrib = phase[i] ? amp_ext : -amp_ext;
         if ((i % 2) == 0)
            mix_l = mix_l + contrib;
         else
            mix_r = mix_r + contrib;
      end
      if (NUM_VOICES == 1)
         mix_r = mix_l;
   end

   function automatic logic signed [15:0] sat16(input logic signed [18:0] s);
      if (s > MIX_MAX)
         return 16'sh7FFF;
      else if (s < MIX_MIN)
         return 16'sh8000;
      else
         return s[15:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         audio_left  <= '0;
         audio_right <= '0;
      end else begin
         audio_left  <= sat16(mix_l);
         audio_right <= sat16(mix_r);
      end
   end

endmodule

// File: tb/tb_poly_voice_alloc.sv
// tb/tb_poly_voice_alloc.sv - scoreboard bench for poly_voice_alloc
module tb_poly_voice_alloc;

   localparam int NV  = 4;
   localparam int DW  = 22;
   localparam int AMP = 'h6000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          key_valid = 1'b0;
   logic [8:0]    key_code = '0;
   logic          key_pressed = 1'b0;
   logic [DW-1:0] note_div = '0;
   logic [NV-1:0] voice_active;
   logic          drop;
   logic [15:0]   audio_left;
   logic [15:0]   audio_right;

   poly_voice_alloc #(
      .NUM_VOICES (NV),
      .DIV_WIDTH  (DW),
      .AMPLITUDE  (16'sh6000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_pressed  (key_pressed),
      .note_div     (note_div),
      .voice_active (voice_active),
      .drop         (drop),
      .audio_left   (audio_left),
      .audio_right  (audio_right)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   typedef struct {
      int          tgt;
      logic [15:0] va;
      logic        drp;
      logic [15:0] al;
      logic [15:0] ar;
   } exp_t;
   exp_t expq[$];

   // reference voice: a tone started at edge t0 has flipped sign every div edges since
   typedef struct {
      bit busy;
      int key;
      int div;
      int t0;
      int seq;
   } voice_t;
   voice_t m[NV];
   int alloc_cnt = 0;

   int n_vec = 0;
   int n_err = 0;

   function automatic int age_of(int v);
      int a;
      a = alloc_cnt - m[v].seq;
      return (a > 7) ? 7 : a;
   endfunction

   function automatic int voice_out(int v);
      if (!m[v].busy || m[v].div == 0) return 0;
      return ((((edge_cnt - m[v].t0) / m[v].div) % 2) == 1) ? AMP : -AMP;
   endfunction

   function automatic logic [15:0] sat(int s);
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return 16'(s);
   endfunction

   task automatic step(input bit r, input bit en, input bit kv, input int kc,
                       input bit kp, input int nd);
      exp_t e;
      int sl;
      int sr;
      int hit;
      int tgt;
      sl = 0;
      sr = 0;
      rst = r; enable = en; key_valid = kv;
      key_code = 9'(kc); key_pressed = kp; note_div = DW'(nd);
      e.tgt = edge_cnt + 1;
      for (int v = 0; v < NV; v++) begin
         if (v % 2 == 0) sl += voice_out(v);
         else            sr += voice_out(v);
      end
      e.al  = (r || !en) ? 16'h0 : sat(sl);
      e.ar  = (r || !en) ? 16'h0 : sat(sr);
      e.drp = 1'b0;
      if (r) begin
         for (int v = 0; v < NV; v++) m[v].busy = 0;
      end else if (kv) begin
         hit = -1;
         for (int v = 0; v < NV; v++)
            if (m[v].busy && m[v].key == kc) hit = v;
         if (kp && hit < 0) begin
            tgt = -1;
            for (int v = NV - 1; v >= 0; v--)
               if (!m[v].busy) tgt = v;
            if (tgt < 0) begin
               e.drp = 1'b1;
`ifdef POLY_VOICE_STEAL_EN
               tgt = 0;
               for (int v = 1; v < NV; v++)
                  if (age_of(v) > age_of(tgt)) tgt = v;
`endif
            end
            if (tgt >= 0) begin
               alloc_cnt++;
               m[tgt] = '{busy: 1, key: kc, div: nd, t0: edge_cnt + 1, seq: alloc_cnt};
            end
         end else if (!kp && hit >= 0) begin
            m[hit].busy = 0;
         end
      end
      e.va = '0;
      for (int v = 0; v < NV; v++) e.va[v] = m[v].busy;
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %h, expected %h", nm, edge_cnt, act, req);
      end
   endtask

   // monitor: every cycle is an output beat; pop what the driver predicted for it
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (expq.size() > 0 && expq[0].tgt <= edge_cnt) begin
            e = expq.pop_front();
            chk("voice_active", 16'(voice_active), e.va);
            chk("drop", 16'(drop), 16'(e.drp));
            chk("audio_left", audio_left, e.al);
            chk("audio_right", audio_right, e.ar);
         end
      end
   end

   int keys[6] = '{'h1C, 'h1B, 'h23, 'h2B, 'h34, 'h15};

   initial begin
      for (int v = 0; v < NV; v++) m[v] = '{busy: 0, key: 0, div: 0, t0: 0, seq: 0};
      #1;
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      // single tone, div 4
      step(0, 1, 1, 'h1C, 1, 4);
      repeat (12) step(0, 1, 0, 0, 0, 0);
      // fill all voices, then one more make
      step(0, 1, 1, 'h1B, 1, 3);
      step(0, 1, 1, 'h23, 1, 2);
      step(0, 1, 1, 'h2B, 1, 5);
      step(0, 1, 1, 'h34, 1, 1);
      repeat (6) step(0, 1, 0, 0, 0, 0);
      // duplicate make, break, unheld break
      step(1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 'h1C, 1, 2);
      step(0, 1, 1, 'h1C, 1, 3);
      step(0, 1, 1, 'h1C, 0, 0);
      step(0, 1, 1, 'h15, 0, 0);
      step(0, 1, 1, 'h1C, 1, 0);
      repeat (3) step(0, 1, 0, 0, 0, 0);
      // two even voices in phase 1 saturate; then mute
      step(1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 'h1C, 1, 1);
      step(0, 1, 1, 'h1B, 1, 1);
      step(0, 1, 1, 'h23, 1, 1);
      repeat (4) step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 'h2B, 1, 2);
      step(0, 1, 0, 0, 0, 0);
      // reset mid-note with a coincident event
      step(1, 1, 1, 'h34, 1, 3);
      step(0, 1, 0, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0),
              ($urandom_range(0, 2) == 0), keys[$urandom_range(0, 5)],
              ($urandom_range(0, 9) < 6), int'($urandom_range(0, 6)));
      end
      step(0, 1, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (expq.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
